// File: rtl/writeback_unit_pkg.sv
// Shared constants for the writeback stage: datapath width, load funct3
// encodings and the writeback FSM state encoding.
package writeback_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2
  } wb_state_e;

endpackage : writeback_unit_pkg

// File: rtl/writeback_unit_load_align.sv
// Load data aligner: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it to XLEN. Unlisted funct3 codes behave as LW.
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] aligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every signal written in always_comb gets a value on every path
  // (full case or default first), otherwise synthesis infers a latch.
  always_comb begin
    case (off_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
  end

  // Halfword selection looks only at off[1]; off[0] is ignored.
  assign half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   aligned_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  aligned_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   aligned_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  aligned_o = {{(XLEN-16){1'b0}}, half_v};
      default: aligned_o = word_i;
    endcase
  end

endmodule : load_align

// File: rtl/writeback_unit.sv
// Writeback stage: accepts ALU results and loads from execute, runs the load
// bus read, and pulses the register-file write port (x0 writes suppressed).
// Optional load-wait timeout enabled by defining RW_WB_LOAD_TIMEOUT_EN.
module writeback_unit
  import writeback_unit_pkg::*;
`ifdef RW_WB_LOAD_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 255
)
`endif
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rdsel_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            ex_is_load_i,
  input  logic [2:0]      ex_funct3_i,
  output logic            ld_req_o,
  output logic [XLEN-1:0] ld_addr_o,
  input  logic            ld_ack_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] rddata_o,
  output logic [4:0]      rdsel_o,
  output logic            phase_writeback_o,
  output logic            ld_err_o
);

  wb_state_e       state_q, state_d;
  logic [4:0]      dst_q, dst_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            ld_req_q, ld_req_d;
  logic [XLEN-1:0] ld_addr_q, ld_addr_d;
  logic [XLEN-1:0] rddata_q, rddata_d;
  logic [4:0]      rdsel_q, rdsel_d;
  logic            wb_q, wb_d;
  logic [XLEN-1:0] aligned;
  logic            accept;

`ifdef RW_WB_LOAD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
  logic        ld_err_q, ld_err_d;
`endif

  load_align u_load_align (
    .funct3_i  (funct3_q),
    .off_i     (off_q),
    .word_i    (ld_rdata_i),
    .aligned_o (aligned)
  );

  // Ready depends on state only, so there is no combinational path from valid.
  assign ex_ready_o = (state_q != ST_LOAD);
  assign accept     = ex_valid_i && ex_ready_o;

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    ld_req_d  = ld_req_q;
    ld_addr_d = ld_addr_q;
    rddata_d  = rddata_q;
    rdsel_d   = rdsel_q;
    wb_d      = 1'b0;
`ifdef RW_WB_LOAD_TIMEOUT_EN
    cnt_d     = cnt_q;
    ld_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_WRITE: begin
        state_d = ST_IDLE;
        if (accept) begin
          dst_d    = ex_rdsel_i;
          funct3_d = ex_funct3_i;
          off_d    = ex_result_i[1:0];
          if (ex_is_load_i) begin
            state_d   = ST_LOAD;
            ld_req_d  = 1'b1;
            ld_addr_d = {ex_result_i[XLEN-1:2], 2'b00};
`ifdef RW_WB_LOAD_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else if (ex_rdsel_i != 5'd0) begin
            state_d  = ST_WRITE;
            wb_d     = 1'b1;
            rddata_d = ex_result_i;
            rdsel_d  = ex_rdsel_i;
          end
        end
      end

      ST_LOAD: begin
        // Ack wins over a simultaneous timeout; a load to x0 still consumes it.
        if (ld_ack_i) begin
          ld_req_d = 1'b0;
          if (dst_q != 5'd0) begin
            state_d  = ST_WRITE;
            wb_d     = 1'b1;
            rddata_d = aligned;
            rdsel_d  = dst_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef RW_WB_LOAD_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TIMEOUT_C) begin
          ld_req_d = 1'b0;
          ld_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dst_q     <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      ld_req_q  <= 1'b0;
      ld_addr_q <= '0;
      rddata_q  <= '0;
      rdsel_q   <= '0;
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      ld_req_q  <= ld_req_d;
      ld_addr_q <= ld_addr_d;
      rddata_q  <= rddata_d;
      rdsel_q   <= rdsel_d;
      wb_q      <= wb_d;
    end
  end

`ifdef RW_WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ld_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign ld_err_o = ld_err_q;
`else
  assign ld_err_o = 1'b0;
`endif

  assign ld_req_o          = ld_req_q;
  assign ld_addr_o         = ld_addr_q;
  assign rddata_o          = rddata_q;
  assign rdsel_o           = rdsel_q;
  assign phase_writeback_o = wb_q;

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; timeout scenarios run
// when RW_WB_LOAD_TIMEOUT_EN is defined (DUT built with TIMEOUT=8).
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rdsel;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic [31:0] rddata;
  logic [4:0]  rdsel;
  logic        phase_writeback;
  logic        ld_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_rddata;
  logic [4:0]  last_rdsel;

`ifdef RW_WB_LOAD_TIMEOUT_EN
  writeback_unit #(.TIMEOUT(8)) dut (
`else
  writeback_unit dut (
`endif
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid),
    .ex_ready_o        (ex_ready),
    .ex_rdsel_i        (ex_rdsel),
    .ex_result_i       (ex_result),
    .ex_is_load_i      (ex_is_load),
    .ex_funct3_i       (ex_funct3),
    .ld_req_o          (ld_req),
    .ld_addr_o         (ld_addr),
    .ld_ack_i          (ld_ack),
    .ld_rdata_i        (ld_rdata),
    .rddata_o          (rddata),
    .rdsel_o           (rdsel),
    .phase_writeback_o (phase_writeback),
    .ld_err_o          (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic alu_issue(input logic [4:0] rd, input logic [31:0] val);
    ex_valid   = 1'b1;
    ex_is_load = 1'b0;
    ex_rdsel   = rd;
    ex_result  = val;
    ex_funct3  = 3'b000;
  endtask

  // Accept a load at the next edge, hold off ack for 'delay' LOAD cycles,
  // then return 'data' and check the write (or its suppression for x0).
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] data, input int delay,
                         input logic [31:0] exp);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rdsel   = rd;
    ex_result  = addr;
    ex_funct3  = f3;
    @(negedge clk);
    ex_valid = 1'b0;
    check({tag, "_req"},   {31'd0, ld_req},   32'd1);
    check({tag, "_addr"},  ld_addr,           addr & 32'hFFFF_FFFC);
    check({tag, "_rdy"},   {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_wreq"},  {31'd0, ld_req},          32'd1);
      check({tag, "_waddr"}, ld_addr,                  addr & 32'hFFFF_FFFC);
      check({tag, "_wrdy"},  {31'd0, ex_ready},        32'd0);
      check({tag, "_wwb"},   {31'd0, phase_writeback}, 32'd0);
    end
    ld_ack   = 1'b1;
    ld_rdata = data;
    @(negedge clk);
    ld_ack   = 1'b0;
    ld_rdata = 32'h0;
    if (rd != 5'd0) begin
      last_rddata = exp;
      last_rdsel  = rd;
    end
    check({tag, "_wb"},     {31'd0, phase_writeback}, (rd != 5'd0) ? 32'd1 : 32'd0);
    check({tag, "_data"},   rddata,                   last_rddata);
    check({tag, "_rdsel"},  {27'd0, rdsel},           {27'd0, last_rdsel});
    check({tag, "_reqlo"},  {31'd0, ld_req},          32'd0);
    check({tag, "_err"},    {31'd0, ld_err},          32'd0);
    @(negedge clk);
    check({tag, "_pulse"},  {31'd0, phase_writeback}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_rdsel = 5'd0; ex_result = 32'h0;
    ex_is_load = 1'b0; ex_funct3 = 3'b000; ld_ack = 1'b0; ld_rdata = 32'h0;
    last_rddata = 32'h0; last_rdsel = 5'd0;

    // Reset state
    @(negedge clk);
    check("rst_ready",  {31'd0, ex_ready},        32'd1);
    check("rst_req",    {31'd0, ld_req},          32'd0);
    check("rst_addr",   ld_addr,                  32'd0);
    check("rst_data",   rddata,                   32'd0);
    check("rst_rdsel",  {27'd0, rdsel},           32'd0);
    check("rst_wb",     {31'd0, phase_writeback}, 32'd0);
    check("rst_err",    {31'd0, ld_err},          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU back-to-back
    alu_issue(5'd5, 32'h1234_5678);
    @(negedge clk);
    check("b2b1_wb",    {31'd0, phase_writeback}, 32'd1);
    check("b2b1_rdsel", {27'd0, rdsel},           32'd5);
    check("b2b1_data",  rddata,                   32'h1234_5678);
    check("b2b1_rdy",   {31'd0, ex_ready},        32'd1);
    alu_issue(5'd6, 32'hCAFE_BABE);
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b2_wb",    {31'd0, phase_writeback}, 32'd1);
    check("b2b2_rdsel", {27'd0, rdsel},           32'd6);
    check("b2b2_data",  rddata,                   32'hCAFE_BABE);
    check("b2b2_rdy",   {31'd0, ex_ready},        32'd1);
    @(negedge clk);
    check("b2b_end_wb", {31'd0, phase_writeback}, 32'd0);
    check("b2b_hold",   rddata,                   32'hCAFE_BABE);
    last_rddata = 32'hCAFE_BABE;
    last_rdsel  = 5'd6;

    // x0 suppression, ALU
    alu_issue(5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    ex_valid = 1'b0;
    check("x0alu_wb",    {31'd0, phase_writeback}, 32'd0);
    check("x0alu_data",  rddata,                   32'hCAFE_BABE);
    check("x0alu_rdsel", {27'd0, rdsel},           32'd6);
    @(negedge clk);
    check("x0alu_wb2",   {31'd0, phase_writeback}, 32'd0);

    // Load alignment, read word 0x80FF7F01 (bytes 01,7F,FF,80)
    do_load("lb_off3",  5'd10, 32'h0000_1003, 3'b000, 32'h80FF_7F01, 0, 32'hFFFF_FF80);
    do_load("lbu_off3", 5'd11, 32'h0000_1003, 3'b100, 32'h80FF_7F01, 0, 32'h0000_0080);
    do_load("lb_off1",  5'd12, 32'h0000_1001, 3'b000, 32'h80FF_7F01, 0, 32'h0000_007F);
    do_load("lb_off2",  5'd13, 32'h0000_1002, 3'b000, 32'h80FF_7F01, 0, 32'hFFFF_FFFF);
    do_load("lbu_off0", 5'd14, 32'h0000_1000, 3'b100, 32'h80FF_7F01, 0, 32'h0000_0001);
    do_load("lh_off2",  5'd15, 32'h0000_2002, 3'b001, 32'h80FF_7F01, 0, 32'hFFFF_80FF);
    do_load("lhu_off0", 5'd16, 32'h0000_2000, 3'b101, 32'h80FF_7F01, 0, 32'h0000_7F01);
    do_load("lh_off1",  5'd17, 32'h0000_2001, 3'b001, 32'h80FF_7F01, 0, 32'h0000_7F01);
    do_load("lhu_off3", 5'd18, 32'h0000_2003, 3'b101, 32'h80FF_7F01, 0, 32'h0000_80FF);
    do_load("lw_off0",  5'd19, 32'h0000_3000, 3'b010, 32'h80FF_7F01, 0, 32'h80FF_7F01);
    do_load("lw_off2",  5'd20, 32'h0000_3002, 3'b010, 32'h80FF_7F01, 0, 32'h80FF_7F01);
    do_load("f3_011",   5'd21, 32'h0000_3001, 3'b011, 32'h80FF_7F01, 0, 32'h80FF_7F01);
    do_load("f3_110",   5'd22, 32'h0000_3003, 3'b110, 32'h80FF_7F01, 0, 32'h80FF_7F01);

    // x0 suppression, load: bus access completes, no write
    do_load("x0ld", 5'd0, 32'h0000_4000, 3'b010, 32'h1111_2222, 1, 32'h1111_2222);

    // Wait states
    do_load("wait4", 5'd9, 32'h0000_5004, 3'b010, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);

    // Reset mid-load
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rdsel = 5'd8;
    ex_result = 32'h0000_6000; ex_funct3 = 3'b010;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rml_req", {31'd0, ld_req}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rml_reqlo", {31'd0, ld_req},          32'd0);
    check("rml_rdy",   {31'd0, ex_ready},        32'd1);
    check("rml_wb",    {31'd0, phase_writeback}, 32'd0);
    check("rml_data",  rddata,                   32'd0);
    check("rml_addr",  ld_addr,                  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ld_ack = 1'b1;
    @(negedge clk);
    ld_ack = 1'b0;
    check("rml_ackign_wb",  {31'd0, phase_writeback}, 32'd0);
    check("rml_ackign_req", {31'd0, ld_req},          32'd0);
    alu_issue(5'd7, 32'hA5A5_A5A5);
    @(negedge clk);
    ex_valid = 1'b0;
    check("rml_alu_wb",    {31'd0, phase_writeback}, 32'd1);
    check("rml_alu_rdsel", {27'd0, rdsel},           32'd7);
    check("rml_alu_data",  rddata,                   32'hA5A5_A5A5);
    last_rddata = 32'hA5A5_A5A5;
    last_rdsel  = 5'd7;
    @(negedge clk);

`ifdef RW_WB_LOAD_TIMEOUT_EN
    // Timeout after 8 LOAD cycles with no ack
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rdsel = 5'd11;
    ex_result = 32'h0000_7000; ex_funct3 = 3'b010;
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to_req_c%0d", i), {31'd0, ld_req}, 32'd1);
      check($sformatf("to_err_c%0d", i), {31'd0, ld_err}, 32'd0);
      if (i < 8) @(negedge clk);
    end
    @(negedge clk);
    check("to_err",   {31'd0, ld_err},          32'd1);
    check("to_reqlo", {31'd0, ld_req},          32'd0);
    check("to_wb",    {31'd0, phase_writeback}, 32'd0);
    check("to_rdy",   {31'd0, ex_ready},        32'd1);
    @(negedge clk);
    check("to_err_pulse", {31'd0, ld_err},          32'd0);
    check("to_wb2",       {31'd0, phase_writeback}, 32'd0);
    check("to_hold",      rddata,                   32'hA5A5_A5A5);

    // Ack on the 8th LOAD cycle wins over the timeout
    do_load("to_ack8", 5'd12, 32'h0000_7004, 3'b010, 32'h0BAD_F00D, 7, 32'h0BAD_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_writeback_unit
